fsk_wave_gen: RTL and testbench

FSK_WAVE_GEN -- requirements
Module: fsk_wave_gen

---
 rtl/fsk_wave_gen.sv | 123 ++++++++++++
 tb/tb_fsk_wave_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_wave_gen.sv
// Phase-accumulator FSK waveform generator with IDLE/RUN/DRAIN sequencing.
// Optional FSK_WAVE_SYNC_SWITCH_EN: tone increment switches only on accumulator wrap.
module fsk_wave_gen #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned OUT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [12:0]      inc_in,
    input  logic             enable,
    input  logic [1:0]       wave_sel,
    output logic [OUT_W-1:0] wave_out,
    output logic             wrap,
    output logic             busy
);

    localparam int unsigned INC_W = 13;
    localparam int unsigned SUM_W = ACC_W + 1;
`ifdef FSK_WAVE_SYNC_SWITCH_EN
    localparam bit SYNC_SWITCH = 1'b1;
`else
    localparam bit SYNC_SWITCH = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [INC_W-1:0]   inc_q, inc_d;
    logic [OUT_W-1:0]   wave_q, wave_d;
    logic               wrap_q, wrap_d;
    logic               busy_q, busy_d;
    logic [SUM_W-1:0]   sum_c;
    logic               carry_c;
    logic [OUT_W-1:0]   tri_c;

    assign sum_c   = {1'b0, acc_q} + SUM_W'(inc_q);
    assign carry_c = sum_c[ACC_W];

    // Waveform shaping from the current accumulator phase
    always_comb begin
        wave_d = '0;
        tri_c  = acc_q[ACC_W-2 -: OUT_W];
        if (acc_q[ACC_W-1]) begin
            tri_c = ~tri_c;
        end
        case (wave_sel)
            2'd0:    wave_d = acc_q[ACC_W-1 -: OUT_W];
            2'd1:    wave_d = {OUT_W{acc_q[ACC_W-1]}};
            2'd2:    wave_d = tri_c;
            default: wave_d = {1'b1, {(OUT_W-1){1'b0}}};
        endcase
    end

    // Next-state and accumulator control
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        inc_d   = inc_q;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                inc_d = inc_in;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = sum_c[ACC_W-1:0];
                wrap_d = carry_c;
                inc_d  = (SYNC_SWITCH && !carry_c) ? inc_q : inc_in;
                if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                acc_d  = sum_c[ACC_W-1:0];
                wrap_d = carry_c;
                inc_d  = (SYNC_SWITCH && !carry_c) ? inc_q : inc_in;
                // A zero step would never wrap, so give up the drain at once
                if (inc_q == '0 || carry_c) begin
                    state_d = IDLE;
                    acc_d   = '0;
                end else if (enable) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            inc_q   <= '0;
            wave_q  <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            inc_q   <= inc_d;
            wave_q  <= wave_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
        end
    end

    assign wave_out = wave_q;
    assign wrap     = wrap_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fsk_wave_gen.sv
// Randomized bench for fsk_wave_gen against an arithmetic reference model.
module tb_fsk_wave_gen;

    localparam int ACC_W = 16;
    localparam int OUT_W = 8;
    localparam int MOD   = 1 << ACC_W;
    localparam int HALF  = 1 << (ACC_W - 1);
    localparam int MAXO  = (1 << OUT_W) - 1;
`ifdef FSK_WAVE_SYNC_SWITCH_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [12:0]      inc_in = '0;
    logic             enable = 1'b0;
    logic [1:0]       wave_sel = '0;
    logic [OUT_W-1:0] wave_out;
    logic             wrap;
    logic             busy;

    int checks = 0;
    int errors = 0;

    int m_mode = M_IDLE;
    int m_acc  = 0;
    int m_inc  = 0;
    int m_wave = 0;
    int m_wrap = 0;
    int m_busy = 0;

    fsk_wave_gen #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .inc_in   (inc_in),
        .enable   (enable),
        .wave_sel (wave_sel),
        .wave_out (wave_out),
        .wrap     (wrap),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wave_of(input int a, input int sel);
        int tr;
        case (sel)
            0: return a / (1 << (ACC_W - OUT_W));
            1: return (a >= HALF) ? MAXO : 0;
            2: begin
                tr = (a / (1 << (ACC_W - 1 - OUT_W))) % (1 << OUT_W);
                return (a >= HALF) ? (MAXO - tr) : tr;
            end
            default: return 1 << (OUT_W - 1);
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_acc = 0; m_inc = 0;
        m_wave = 0; m_wrap = 0; m_busy = 0;
    endtask

    // One rising edge of the reference behaviour, using pre-edge inputs
    task automatic model_edge(input int en, input int inc_v, input int sel);
        int s;
        bit c;
        m_wave = wave_of(m_acc, sel);
        m_wrap = 0;
        if (m_mode == M_IDLE) begin
            m_acc = 0;
            m_inc = inc_v;
            if (en != 0) m_mode = M_RUN;
        end else begin
            s = m_acc + m_inc;
            c = (s >= MOD);
            m_wrap = c ? 1 : 0;
            if (m_mode == M_DRAIN && (m_inc == 0 || c)) begin
                m_mode = M_IDLE;
                m_acc  = 0;
            end else begin
                m_acc = s % MOD;
                if (m_mode == M_RUN && en == 0) m_mode = M_DRAIN;
                else if (m_mode == M_DRAIN && en != 0) m_mode = M_RUN;
            end
            if (!SYNC || c) m_inc = inc_v;
        end
        m_busy = (m_mode != M_IDLE) ? 1 : 0;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge(int'(enable), int'(inc_in), int'(wave_sel));
        #1;
        check_val("wave_out", int'(wave_out), m_wave);
        check_val("wrap", int'(wrap), m_wrap);
        check_val("busy", int'(busy), m_busy);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        check_val("rst_wave", int'(wave_out), 0);
        check_val("rst_busy", int'(busy), 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_val("post_rel_busy", int'(busy), 0);
    endtask

    function automatic logic [12:0] rand_inc();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) return 13'd88;
        if (r < 3) return 13'd13;
        if (r < 4) return 13'd0;
        return 13'($urandom_range(200, 8191));
    endfunction

    initial begin
        int first;
        int cnt;
        int nwrap;

        // Power-up: enable and tone held through reset release
        enable = 1'b1; inc_in = 13'd88; wave_sel = 2'd0;
        do_reset();
        first = -1;
        for (int i = 1; i <= 1000 && first < 0; i++) begin
            step();
            if (i == 1) check_val("busy_first_edge", int'(busy), 1);
            if (wrap) first = i;
        end
        check_val("first_wrap_edge", first, 1 + (MOD + 87) / 88);

        // Tone change mid-cycle at acc >= 30000
        cnt = 0;
        while (m_acc < 30000 && cnt < 2000) begin step(); cnt++; end
        inc_in = 13'd13;
        nwrap = 0;
        for (int i = 0; i < 12000 && nwrap < 2; i++) begin
            step();
            if (wrap) nwrap++;
        end
        check_val("tone_switch_wraps", nwrap, 2);

        // Drain from acc >= 0x4000 with inc 88
        do_reset();
        inc_in = 13'd88; enable = 1'b1;
        cnt = 0;
        while (m_acc < 16384 && cnt < 2000) begin step(); cnt++; end
        enable = 1'b0;
        nwrap = 0;
        cnt = 0;
        do begin
            step();
            if (wrap) nwrap++;
            cnt++;
        end while (busy && cnt < 2000);
        check_val("drain_wrap_count", nwrap, 1);
        check_val("drain_idle", int'(busy), 0);
        for (int i = 0; i < 20; i++) step();

        // Zero increment: RUN -> DRAIN -> IDLE
        inc_in = 13'd0; enable = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        enable = 1'b0;
        step();
        check_val("zero_inc_drain_busy", int'(busy), 1);
        step();
        check_val("zero_inc_idle_busy", int'(busy), 0);

        // Waveform sweep over a full period
        do_reset();
        inc_in = 13'd88; enable = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            wave_sel = 2'(i % 4);
            step();
        end

        // Async reset mid-RUN, no clock edge
        wave_sel = 2'd3; inc_in = 13'd500;
        for (int i = 0; i < 10; i++) step();
        check_val("pre_async_busy", int'(busy), 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_val("async_wave", int'(wave_out), 0);
        check_val("async_wrap", int'(wrap), 0);
        check_val("async_busy", int'(busy), 0);
        @(negedge clock);
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 20000; i++) begin
            enable   = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 7) == 0) inc_in = rand_inc();
            wave_sel = 2'($urandom_range(0, 3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
